// File: rtl/block_mac_2x2_if.sv
// Operand/result bundle between the matmul control unit (master) and the
// 2x2 block MAC engine (slave).
interface block_mac_2x2_if #(
  parameter int data_w = 32
);
  logic              start;
  logic              acc_clr;
  logic [data_w-1:0] a_11, a_12, a_21, a_22;
  logic [data_w-1:0] b_11, b_12, b_21, b_22;
  logic [data_w-1:0] c_11, c_12, c_21, c_22;
  logic              done;
  logic              busy;

  modport master (
    output start, acc_clr, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    input  c_11, c_12, c_21, c_22, done, busy
  );

  modport slave (
    input  start, acc_clr, a_11, a_12, a_21, a_22, b_11, b_12, b_21, b_22,
    output c_11, c_12, c_21, c_22, done, busy
  );
endinterface

// File: rtl/block_mac_2x2.sv
// Sequential 2x2 block multiply-accumulate: C = A*B or C += A*B, using one
// shared multiplier stepped over the eight partial products.
module block_mac_2x2 #(
  parameter int data_w = 32
) (
  input logic            clk,
  input logic            rst,
  block_mac_2x2_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              load_s;
  logic [2:0]        step_r;
  logic [data_w-1:0] a11_r, a12_r, a21_r, a22_r;
  logic [data_w-1:0] b11_r, b12_r, b21_r, b22_r;
  logic [data_w-1:0] w11_r, w12_r, w21_r, w22_r;
  logic [data_w-1:0] c11_r, c12_r, c21_r, c22_r;
  logic [data_w-1:0] mul_a_s, mul_b_s, prod_s;
  logic              done_r, busy_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic; DONE accepts a new start exactly like IDLE
  always_comb begin
    state_nxt_s = IDLE;
    load_s      = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          load_s      = 1'b1;
          state_nxt_s = MUL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      MUL: begin
        if (step_r == 3'd7) state_nxt_s = DONE;
        else                state_nxt_s = MUL;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand select: step bits {s2,s0} pick A[row][col], {s0,s1} pick B[row][col]
  always_comb begin
    mul_a_s = {data_w{1'b0}};
    mul_b_s = {data_w{1'b0}};
    case ({step_r[2], step_r[0]})
      2'b00:   mul_a_s = a11_r;
      2'b01:   mul_a_s = a12_r;
      2'b10:   mul_a_s = a21_r;
      2'b11:   mul_a_s = a22_r;
      default: mul_a_s = {data_w{1'b0}};
    endcase
    case ({step_r[0], step_r[1]})
      2'b00:   mul_b_s = b11_r;
      2'b01:   mul_b_s = b12_r;
      2'b10:   mul_b_s = b21_r;
      2'b11:   mul_b_s = b22_r;
      default: mul_b_s = {data_w{1'b0}};
    endcase
  end

  // Self-determined width keeps only the low data_w bits of the product
  assign prod_s = mul_a_s * mul_b_s;

  // Datapath: operand latch, accumulation, result commit and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_r <= 3'd0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
      a11_r <= {data_w{1'b0}}; a12_r <= {data_w{1'b0}};
      a21_r <= {data_w{1'b0}}; a22_r <= {data_w{1'b0}};
      b11_r <= {data_w{1'b0}}; b12_r <= {data_w{1'b0}};
      b21_r <= {data_w{1'b0}}; b22_r <= {data_w{1'b0}};
      w11_r <= {data_w{1'b0}}; w12_r <= {data_w{1'b0}};
      w21_r <= {data_w{1'b0}}; w22_r <= {data_w{1'b0}};
      c11_r <= {data_w{1'b0}}; c12_r <= {data_w{1'b0}};
      c21_r <= {data_w{1'b0}}; c22_r <= {data_w{1'b0}};
    end else begin
      done_r <= (state_nxt_s == DONE);
      busy_r <= (state_nxt_s == MUL);
      if (load_s) begin
        step_r <= 3'd0;
        a11_r <= bus.a_11; a12_r <= bus.a_12; a21_r <= bus.a_21; a22_r <= bus.a_22;
        b11_r <= bus.b_11; b12_r <= bus.b_12; b21_r <= bus.b_21; b22_r <= bus.b_22;
        w11_r <= bus.acc_clr ? {data_w{1'b0}} : c11_r;
        w12_r <= bus.acc_clr ? {data_w{1'b0}} : c12_r;
        w21_r <= bus.acc_clr ? {data_w{1'b0}} : c21_r;
        w22_r <= bus.acc_clr ? {data_w{1'b0}} : c22_r;
      end else if (state_r == MUL) begin
        step_r <= step_r + 3'd1;
        case (step_r[2:1])
          2'd0:    w11_r <= w11_r + prod_s;
          2'd1:    w12_r <= w12_r + prod_s;
          2'd2:    w21_r <= w21_r + prod_s;
          2'd3:    w22_r <= w22_r + prod_s;
          default: w11_r <= w11_r;
        endcase
        // Last step feeds w22 directly, so its product is folded in here
        if (step_r == 3'd7) begin
          c11_r <= w11_r;
          c12_r <= w12_r;
          c21_r <= w21_r;
          c22_r <= w22_r + prod_s;
        end
      end
    end
  end

  assign bus.c_11 = c11_r;
  assign bus.c_12 = c12_r;
  assign bus.c_21 = c21_r;
  assign bus.c_22 = c22_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_block_mac_2x2.sv
// Self-checking bench for block_mac_2x2: directed test-plan steps plus random
// operations compared against a plain matrix-arithmetic reference.
module tb_block_mac_2x2;
  typedef logic [3:0][31:0] mat_t;  // [0]=x11 [1]=x12 [2]=x21 [3]=x22

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  mat_t model_c  = '0;

  block_mac_2x2_if #(.data_w(32)) bus ();
  block_mac_2x2 #(.data_w(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic mat_t mk(input logic [31:0] x11, x12, x21, x22);
    return {x22, x21, x12, x11};
  endfunction

  // Reference: ordinary 2x2 matrix product, all arithmetic mod 2^32
  function automatic mat_t mm(input mat_t a, input mat_t b, input logic clr, input mat_t cp);
    mat_t        r;
    logic [31:0] acc;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        acc = clr ? 32'd0 : cp[i*2+j];
        for (int k = 0; k < 2; k++) acc = acc + a[i*2+k] * b[k*2+j];
        r[i*2+j] = acc;
      end
    end
    return r;
  endfunction

  function automatic mat_t dut_c();
    return {bus.c_22, bus.c_21, bus.c_12, bus.c_11};
  endfunction

  function automatic mat_t rnd_mat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input mat_t a, input mat_t b, input logic clr);
    bus.a_11 = a[0]; bus.a_12 = a[1]; bus.a_21 = a[2]; bus.a_22 = a[3];
    bus.b_11 = b[0]; bus.b_12 = b[1]; bus.b_21 = b[2]; bus.b_22 = b[3];
    bus.acc_clr = clr;
  endtask

  // Called at a negedge; start is sampled on the next posedge (edge T).
  // glitch_k >= 0 re-pulses start with junk operands during MUL.
  // chain=1 returns inside the done cycle so the next op starts back-to-back.
  task automatic op(input string tag, input mat_t a, input mat_t b, input logic clr,
                    input int glitch_k, input bit chain);
    mat_t exp_c;
    exp_c = mm(a, b, clr, model_c);
    set_inputs(a, b, clr);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    set_inputs(rnd_mat(), rnd_mat(), 1'($urandom_range(1, 0)));
    for (int k = 0; k < 8; k++) begin
      check($sformatf("%s_busy_done_k%0d", tag, k), {126'd0, bus.busy, bus.done}, {126'd0, 2'b10});
      check($sformatf("%s_c_hold_k%0d", tag, k), dut_c(), model_c);
      bus.start = (k == glitch_k);
      if (k == glitch_k) set_inputs(rnd_mat(), rnd_mat(), 1'b1);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({tag, "_done"}, {126'd0, bus.busy, bus.done}, {126'd0, 2'b01});
    check({tag, "_c"}, dut_c(), exp_c);
    model_c = exp_c;
    if (!chain) begin
      @(negedge clk);
      check({tag, "_idle"}, {126'd0, bus.busy, bus.done}, 128'd0);
      check({tag, "_c_keep"}, dut_c(), exp_c);
    end
  endtask

  initial begin
    mat_t ma, mb;
    bus.start = 1'b0;
    set_inputs('0, '0, 1'b0);

    // Asynchronous reset mid-cycle, visible before any clock edge
    #2 rst = 1'b1;
    #1;
    check("reset_c", dut_c(), 128'd0);
    check("reset_flags", {126'd0, bus.busy, bus.done}, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Clear multiply, accumulate, identity
    ma = mk(32'd1, 32'd2, 32'd3, 32'd4);
    mb = mk(32'd5, 32'd6, 32'd7, 32'd8);
    op("clr_mul", ma, mb, 1'b1, -1, 1'b0);
    check("clr_mul_lit", dut_c(), mk(32'd19, 32'd22, 32'd43, 32'd50));
    op("accum", ma, mb, 1'b0, -1, 1'b0);
    check("accum_lit", dut_c(), mk(32'd38, 32'd44, 32'd86, 32'd100));
    op("ident", mk(32'd1, 32'd0, 32'd0, 32'd1), mk(32'd9, 32'd8, 32'd7, 32'd6), 1'b1, -1, 1'b0);
    check("ident_lit", dut_c(), mk(32'd9, 32'd8, 32'd7, 32'd6));

    // Wrap / truncation
    op("wrap_ff", mk(32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0), mk(32'd2, 32'd0, 32'd0, 32'd0), 1'b1, -1, 1'b0);
    check("wrap_ff_lit", dut_c(), mk(32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0));
    op("wrap_80", mk(32'h8000_0000, 32'd0, 32'd0, 32'd0), mk(32'd2, 32'd0, 32'd0, 32'd0), 1'b1, -1, 1'b0);
    check("wrap_80_lit", dut_c(), 128'd0);

    // Start during MUL (sampled at T+3) is ignored
    op("ignore", ma, mb, 1'b1, 2, 1'b0);
    check("ignore_lit", dut_c(), mk(32'd19, 32'd22, 32'd43, 32'd50));

    // Back-to-back: start in the done cycle, second op accumulates on the first
    op("chain0", mk(32'd2, 32'd0, 32'd0, 32'd2), mb, 1'b1, -1, 1'b1);
    op("chain1", ma, mb, 1'b0, -1, 1'b0);
    check("chain1_lit", dut_c(), mk(32'd29, 32'd34, 32'd57, 32'd66));

    // Reset abort at T+5: no done pulse, results cleared
    set_inputs(ma, mb, 1'b1);
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", {127'd0, bus.busy}, 128'd1);
    #1 rst = 1'b1;
    #1;
    check("abort_c", dut_c(), 128'd0);
    check("abort_flags", {126'd0, bus.busy, bus.done}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("abort_quiet_%0d", k), {dut_c(), 2'b00} | {126'd0, bus.busy, bus.done}, 128'd0);
    end
    model_c = '0;
    op("after_abort", ma, mb, 1'b0, -1, 1'b0);
    check("after_abort_lit", dut_c(), mk(32'd19, 32'd22, 32'd43, 32'd50));

    // Random operations, random clear/accumulate, chaining and ignored starts
    for (int n = 0; n < 12; n++) begin
      op($sformatf("rnd%0d", n), rnd_mat(), rnd_mat(), 1'($urandom_range(1, 0)),
         $urandom_range(7, 0) - 1, (n != 11) && ($urandom_range(1, 0) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
